// File: rtl/memory_access.sv
// Memory stage of the RV64 pipeline: request/response handshake to the data bus,
// store lane replication, load alignment/extension, and upstream stall generation.
module memory_access #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         regM_i_valid,
    input  logic [160:0] regM_i_commit_info,
    input  logic [10:0]  regM_i_load_store_info,
    input  logic [63:0]  regM_i_alu_result,
    input  logic [63:0]  regM_i_regdata2,
    output logic         dmem_o_req_valid,
    input  logic         dmem_i_req_ready,
    output logic [63:0]  dmem_o_addr,
    output logic         dmem_o_wen,
    output logic [63:0]  dmem_o_wdata,
    output logic [7:0]   dmem_o_wstrb,
    input  logic         dmem_i_rsp_valid,
    input  logic [63:0]  dmem_i_rdata,
    output logic         memory_o_valid,
    output logic [160:0] memory_o_commit_info,
    output logic [63:0]  memory_o_result,
    output logic         memory_o_misaligned,
    output logic         memory_o_bus_err,
    output logic         memory_o_stall
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;

    typedef enum logic [3:0] {
        OP_NONE, OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } op_e;

    // Wide enough to hold TIMEOUT itself, and at least one bit when TIMEOUT is 0.
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [2:0]         off_q, off_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        addr_q, addr_d;
    logic               wen_q, wen_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [7:0]         wstrb_q, wstrb_d;
    logic [160:0]       commit_q, commit_d;
    logic [63:0]        result_q, result_d;
    logic               mis_q, mis_d;
    logic               berr_q, berr_d;

    op_e                in_op;
    logic [2:0]         in_off;
    logic               in_mis;
    logic               in_store;
    logic [63:0]        in_wdata;
    logic [7:0]         in_wstrb;
    logic [CNT_W-1:0]   cnt_inc;

    function automatic logic [63:0] load_value(op_e op, logic [2:0] off, logic [63:0] rdata);
        logic [63:0] sh;
        sh = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   return {{56{sh[7]}}, sh[7:0]};
            OP_LH:   return {{48{sh[15]}}, sh[15:0]};
            OP_LW:   return {{32{sh[31]}}, sh[31:0]};
            OP_LBU:  return {56'd0, sh[7:0]};
            OP_LHU:  return {48'd0, sh[15:0]};
            OP_LWU:  return {32'd0, sh[31:0]};
            default: return rdata;
        endcase
    endfunction

    // Operation decode; the highest set bit wins when the one-hot is violated.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        in_op = OP_NONE;
        if      (regM_i_load_store_info[10]) in_op = OP_LB;
        else if (regM_i_load_store_info[9])  in_op = OP_LH;
        else if (regM_i_load_store_info[8])  in_op = OP_LW;
        else if (regM_i_load_store_info[7])  in_op = OP_LD;
        else if (regM_i_load_store_info[6])  in_op = OP_LBU;
        else if (regM_i_load_store_info[5])  in_op = OP_LHU;
        else if (regM_i_load_store_info[4])  in_op = OP_LWU;
        else if (regM_i_load_store_info[3])  in_op = OP_SB;
        else if (regM_i_load_store_info[2])  in_op = OP_SH;
        else if (regM_i_load_store_info[1])  in_op = OP_SW;
        else if (regM_i_load_store_info[0])  in_op = OP_SD;
    end

    always_comb begin
        in_off   = regM_i_alu_result[2:0];
        in_store = (in_op == OP_SB) || (in_op == OP_SH) || (in_op == OP_SW) || (in_op == OP_SD);
        in_mis   = 1'b0;
        in_wdata = regM_i_regdata2;
        in_wstrb = 8'hFF;
        case (in_op)
            OP_LH, OP_LHU, OP_SH: in_mis = in_off[0];
            OP_LW, OP_LWU, OP_SW: in_mis = |in_off[1:0];
            OP_LD, OP_SD:         in_mis = |in_off;
            default:              in_mis = 1'b0;
        endcase
        case (in_op)
            OP_SB: begin
                in_wdata = {8{regM_i_regdata2[7:0]}};
                in_wstrb = 8'h01 << in_off;
            end
            OP_SH: begin
                in_wdata = {4{regM_i_regdata2[15:0]}};
                in_wstrb = 8'h03 << in_off;
            end
            OP_SW: begin
                in_wdata = {2{regM_i_regdata2[31:0]}};
                in_wstrb = 8'h0F << in_off;
            end
            default: ;
        endcase
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        commit_d = commit_q;
        result_d = result_q;
        mis_d    = 1'b0;
        berr_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (regM_i_valid) begin
                    op_d     = in_op;
                    off_d    = in_off;
                    commit_d = regM_i_commit_info;
                    if (in_op == OP_NONE) begin
                        state_d  = DONE;
                        result_d = regM_i_alu_result;
                    end else if (in_mis) begin
                        state_d  = DONE;
                        mis_d    = 1'b1;
                        result_d = 64'd0;
                    end else begin
                        state_d  = REQ;
                        addr_d   = {regM_i_alu_result[63:3], 3'b000};
                        wen_d    = in_store;
                        wdata_d  = in_wdata;
                        wstrb_d  = in_wstrb;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (dmem_i_req_ready) begin
                    if (wen_q) begin
                        state_d  = DONE;
                        result_d = 64'd0;
                    end else begin
                        state_d = WAIT_RSP;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem_i_rsp_valid) begin
                    state_d  = DONE;
                    result_d = load_value(op_q, off_q, dmem_i_rdata);
                end else begin
                    cnt_d = cnt_inc;
                    if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
                        state_d  = DONE;
                        berr_d   = 1'b1;
                        result_d = 64'd0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_NONE;
            off_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            commit_q <= '0;
            result_q <= '0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            commit_q <= commit_d;
            result_q <= result_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    assign dmem_o_req_valid     = (state_q == REQ);
    assign dmem_o_addr          = addr_q;
    assign dmem_o_wen           = wen_q;
    assign dmem_o_wdata         = wdata_q;
    assign dmem_o_wstrb         = wstrb_q;
    assign memory_o_valid       = (state_q == DONE);
    assign memory_o_commit_info = commit_q;
    assign memory_o_result      = result_q;
    assign memory_o_misaligned  = mis_q;
    assign memory_o_bus_err     = berr_q;
    assign memory_o_stall       = (state_q == REQ) || (state_q == WAIT_RSP);

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access: a bus responder with programmable delays and a
// reference model computing alignment, lanes and extension with plain arithmetic.
module tb_memory_access;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         regM_i_valid = 1'b0;
    logic [160:0] regM_i_commit_info = '0;
    logic [10:0]  regM_i_load_store_info = '0;
    logic [63:0]  regM_i_alu_result = '0;
    logic [63:0]  regM_i_regdata2 = '0;
    logic         dmem_o_req_valid;
    logic         dmem_i_req_ready = 1'b0;
    logic [63:0]  dmem_o_addr;
    logic         dmem_o_wen;
    logic [63:0]  dmem_o_wdata;
    logic [7:0]   dmem_o_wstrb;
    logic         dmem_i_rsp_valid = 1'b0;
    logic [63:0]  dmem_i_rdata = '0;
    logic         memory_o_valid;
    logic [160:0] memory_o_commit_info;
    logic [63:0]  memory_o_result;
    logic         memory_o_misaligned;
    logic         memory_o_bus_err;
    logic         memory_o_stall;

    memory_access #(.TIMEOUT(TO)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .regM_i_valid           (regM_i_valid),
        .regM_i_commit_info     (regM_i_commit_info),
        .regM_i_load_store_info (regM_i_load_store_info),
        .regM_i_alu_result      (regM_i_alu_result),
        .regM_i_regdata2        (regM_i_regdata2),
        .dmem_o_req_valid       (dmem_o_req_valid),
        .dmem_i_req_ready       (dmem_i_req_ready),
        .dmem_o_addr            (dmem_o_addr),
        .dmem_o_wen             (dmem_o_wen),
        .dmem_o_wdata           (dmem_o_wdata),
        .dmem_o_wstrb           (dmem_o_wstrb),
        .dmem_i_rsp_valid       (dmem_i_rsp_valid),
        .dmem_i_rdata           (dmem_i_rdata),
        .memory_o_valid         (memory_o_valid),
        .memory_o_commit_info   (memory_o_commit_info),
        .memory_o_result        (memory_o_result),
        .memory_o_misaligned    (memory_o_misaligned),
        .memory_o_bus_err       (memory_o_bus_err),
        .memory_o_stall         (memory_o_stall)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [160:0] got, input logic [160:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       none;
        logic       store;
        logic [3:0] size;
        logic       sgn;
    } op_t;

    // Bit index -> access size in bytes, following the one-hot layout.
    function automatic op_t decode(input logic [10:0] ls);
        op_t r;
        r = '{none: 1'b1, store: 1'b0, size: 4'd0, sgn: 1'b0};
        for (int b = 0; b <= 10; b++) begin
            if (ls[b]) begin
                r.none  = 1'b0;
                r.store = (b <= 3);
                r.sgn   = (b >= 8);
                case (b)
                    10, 6, 3: r.size = 4'd1;
                    9, 5, 2:  r.size = 4'd2;
                    8, 4, 1:  r.size = 4'd4;
                    default:  r.size = 4'd8;
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [160:0] rand161();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[160:0];
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk_done(input string nm, input bit chk_res, input logic [63:0] res,
                            input logic mis, input logic berr, input logic [160:0] ci);
        check($sformatf("%s.valid", nm), memory_o_valid, 1'b1);
        check($sformatf("%s.stall_done", nm), memory_o_stall, 1'b0);
        check($sformatf("%s.req_done", nm), dmem_o_req_valid, 1'b0);
        check($sformatf("%s.misaligned", nm), memory_o_misaligned, mis);
        check($sformatf("%s.bus_err", nm), memory_o_bus_err, berr);
        check($sformatf("%s.commit", nm), memory_o_commit_info, ci);
        if (chk_res) check($sformatf("%s.result", nm), memory_o_result, res);
    endtask

    task automatic do_txn(input string nm, input logic [10:0] ls, input logic [63:0] addr,
                          input logic [63:0] d2, input logic [63:0] rdata,
                          input int rdy_dly, input int rsp_dly);
        op_t          op;
        logic [63:0]  mask, exp_wdata, exp_res, v;
        logic [7:0]   exp_wstrb;
        logic [160:0] ci;
        logic         mis, timeout;
        int           o;
        op        = decode(ls);
        o         = int'(addr[2:0]);
        ci        = rand161();
        mis       = 1'b0;
        mask      = '0;
        exp_wdata = '0;
        exp_wstrb = '0;
        if (!op.none) begin
            mis       = (o % int'(op.size)) != 0;
            mask      = (op.size == 4'd8) ? '1 : ((64'd1 << (8 * op.size)) - 64'd1);
            exp_wstrb = 8'(((1 << op.size) - 1) << o);
            for (int i = 0; i < 8 / int'(op.size); i++)
                exp_wdata |= (d2 & mask) << (i * 8 * int'(op.size));
        end
        timeout = !op.none && !mis && !op.store && (rsp_dly >= TO);
        if (op.none) exp_res = addr;
        else if (mis || op.store || timeout) exp_res = '0;
        else begin
            v = (rdata >> (8 * o)) & mask;
            if (op.sgn && v[8 * op.size - 1]) v |= ~mask;
            exp_res = v;
        end

        @(negedge clk);
        check($sformatf("%s.stall_acc", nm), memory_o_stall, 1'b0);
        regM_i_valid           = 1'b1;
        regM_i_load_store_info = ls;
        regM_i_alu_result      = addr;
        regM_i_regdata2        = d2;
        regM_i_commit_info     = ci;
        @(negedge clk);
        regM_i_valid           = 1'b0;
        regM_i_load_store_info = 11'($urandom);
        regM_i_alu_result      = rand64();
        regM_i_regdata2        = rand64();
        regM_i_commit_info     = rand161();

        if (op.none || mis) begin
            chk_done(nm, 1'b1, exp_res, mis, 1'b0, ci);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                check($sformatf("%s.req_valid", nm), dmem_o_req_valid, 1'b1);
                check($sformatf("%s.stall_req", nm), memory_o_stall, 1'b1);
                check($sformatf("%s.valid_req", nm), memory_o_valid, 1'b0);
                check($sformatf("%s.addr", nm), dmem_o_addr, addr & ~64'h7);
                check($sformatf("%s.wen", nm), dmem_o_wen, op.store);
                if (op.store) begin
                    check($sformatf("%s.wdata", nm), dmem_o_wdata, exp_wdata);
                    check($sformatf("%s.wstrb", nm), dmem_o_wstrb, exp_wstrb);
                end
                if (i == rdy_dly) dmem_i_req_ready = 1'b1;
                @(negedge clk);
            end
            dmem_i_req_ready = 1'b0;
            check($sformatf("%s.req_drop", nm), dmem_o_req_valid, 1'b0);
            if (op.store) begin
                chk_done(nm, 1'b0, '0, 1'b0, 1'b0, ci);
            end else begin
                for (int i = 0; i < (timeout ? TO : rsp_dly); i++) begin
                    check($sformatf("%s.valid_wait", nm), memory_o_valid, 1'b0);
                    check($sformatf("%s.stall_wait", nm), memory_o_stall, 1'b1);
                    @(negedge clk);
                end
                if (!timeout) begin
                    dmem_i_rsp_valid = 1'b1;
                    dmem_i_rdata     = rdata;
                    @(negedge clk);
                    dmem_i_rsp_valid = 1'b0;
                    dmem_i_rdata     = rand64();
                end
                chk_done(nm, 1'b1, exp_res, 1'b0, timeout, ci);
            end
        end
        // A stray response during DONE/IDLE must not produce another completion.
        dmem_i_rsp_valid = 1'b1;
        @(negedge clk);
        dmem_i_rsp_valid = 1'b0;
        check($sformatf("%s.valid_drop", nm), memory_o_valid, 1'b0);
        check($sformatf("%s.stall_idle", nm), memory_o_stall, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] vals [5];
        logic [10:0] ls;
        logic [63:0] a;

        repeat (2) @(negedge clk);
        check("rst.req_valid", dmem_o_req_valid, 1'b0);
        check("rst.valid", memory_o_valid, 1'b0);
        check("rst.stall", memory_o_stall, 1'b0);
        check("rst.result", memory_o_result, 64'd0);
        check("rst.addr", dmem_o_addr, 64'd0);
        check("rst.wstrb", dmem_o_wstrb, 8'd0);
        check("rst.flags", {memory_o_misaligned, memory_o_bus_err, dmem_o_wen}, 3'b000);
        check("rst.commit", memory_o_commit_info, 161'd0);
        rst_n = 1'b1;

        do_txn("lb",   11'b100_0000_0000, 64'h1003, rand64(), 64'h0000_0000_8000_0000, 0, 0);
        do_txn("sw",   11'b000_0000_0010, 64'h2004, 64'h1122_3344_AABB_CCDD, '0, 0, 0);
        do_txn("ld",   11'b000_1000_0000, 64'h3000, rand64(), 64'hDEAD_BEEF_0123_4567, 3, 2);
        do_txn("lw_mis", 11'b001_0000_0000, 64'h4002, rand64(), rand64(), 0, 0);
        do_txn("lhu_to", 11'b000_0010_0000, 64'h5006, rand64(), rand64(), 0, 10);
        do_txn("sd_mis", 11'b000_0000_0001, 64'h6004, rand64(), rand64(), 0, 0);
        do_txn("multi", 11'b001_0000_1000, 64'h7004, rand64(), 64'h8765_4321_F00D_CAFE, 1, 3);

        // Reset while a load waits for its response.
        @(negedge clk);
        regM_i_valid = 1'b1; regM_i_load_store_info = 11'b000_1000_0000;
        regM_i_alu_result = 64'h8000; regM_i_commit_info = rand161();
        @(negedge clk);
        regM_i_valid = 1'b0;
        dmem_i_req_ready = 1'b1;
        @(negedge clk);
        dmem_i_req_ready = 1'b0;
        check("rstw.stall_before", memory_o_stall, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstw.req_valid", dmem_o_req_valid, 1'b0);
        check("rstw.stall", memory_o_stall, 1'b0);
        check("rstw.valid", memory_o_valid, 1'b0);
        check("rstw.result", memory_o_result, 64'd0);
        dmem_i_rsp_valid = 1'b1; dmem_i_rdata = rand64();
        @(negedge clk);
        dmem_i_rsp_valid = 1'b0;
        check("rstw.late_rsp", memory_o_valid, 1'b0);

        // Reset while a store request is still waiting for ready.
        regM_i_valid = 1'b1; regM_i_load_store_info = 11'b000_0000_1000;
        regM_i_alu_result = 64'h9001;
        @(negedge clk);
        regM_i_valid = 1'b0;
        check("rstr.req_before", dmem_o_req_valid, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstr.req_valid", dmem_o_req_valid, 1'b0);
        check("rstr.wen", dmem_o_wen, 1'b0);

        // Back-to-back non-memory ops: accept in DONE gives a completion every cycle.
        for (int k = 0; k < 5; k++) vals[k] = rand64();
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) begin
                check("b2b.valid", memory_o_valid, 1'b1);
                check("b2b.result", memory_o_result, vals[k-1]);
                check("b2b.stall", memory_o_stall, 1'b0);
            end
            regM_i_valid = (k < 5);
            regM_i_load_store_info = '0;
            regM_i_alu_result = (k < 5) ? vals[k] : 64'd0;
            @(negedge clk);
        end
        check("b2b.end", memory_o_valid, 1'b0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    ls = '0;
                9:       ls = 11'($urandom);
                default: ls = 11'(1) << $urandom_range(0, 10);
            endcase
            a = rand64();
            if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
            else if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
            do_txn($sformatf("rnd%0d", n), ls, a, rand64(), rand64(),
                   $urandom_range(0, 3), $urandom_range(0, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
